// File: rtl/step_sequencer.sv
// Tempo-driven note step sequencer over a writable pattern RAM.
// Optional per-step accent bit enabled by defining SEQ_ACCENT_EN.
module step_sequencer #(
  parameter int ADDR_W = 4,
  parameter int NOTE_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_in,
  input  logic              run,
  input  logic [ADDR_W-1:0] len_m1,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
`ifdef SEQ_ACCENT_EN
  input  logic [NOTE_W:0]   wr_data,
`else
  input  logic [NOTE_W-1:0] wr_data,
`endif
  output logic [NOTE_W-1:0] note,
  output logic              gate,
  output logic              step_strobe,
  output logic [ADDR_W-1:0] step_idx,
  output logic              playing
`ifdef SEQ_ACCENT_EN
  ,
  output logic              accent
`endif
);

  localparam int STEPS = 2 ** ADDR_W;
`ifdef SEQ_ACCENT_EN
  localparam int DW = NOTE_W + 1;
`else
  localparam int DW = NOTE_W;
`endif

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    PLAYING
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DW-1:0]     r_mem [STEPS];
  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic              w_rise;
  logic              w_fall;
  logic              w_play;
  logic [ADDR_W-1:0] w_nidx;
  logic [DW-1:0]     w_rd;
  logic [NOTE_W-1:0] r_note;
  logic              r_gate;
  logic              r_strobe;
  logic [ADDR_W-1:0] r_idx;
  logic              r_acc;

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_rd   = r_mem[w_nidx];

  // Synchronise the tempo input and keep one history bit for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= tick_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Pattern RAM; reads are combinational so a same-edge write is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus the step to play on this edge, if any.
  always_comb begin
    w_next = r_state;
    w_play = 1'b0;
    w_nidx = '0;
    unique case (r_state)
      IDLE: begin
        if (run) w_next = ARMED;
      end
      ARMED: begin
        if (!run) begin
          w_next = IDLE;
        end else if (w_rise) begin
          w_next = PLAYING;
          w_play = 1'b1;
        end
      end
      PLAYING: begin
        if (!run) begin
          w_next = IDLE;
        end else if (w_rise) begin
          w_play = 1'b1;
          w_nidx = (r_idx >= len_m1) ? '0
                 : r_idx + ADDR_W'(1);
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Output registers: load a step on play, drop the gate on fall or stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_note   <= '0;
      r_gate   <= 1'b0;
      r_strobe <= 1'b0;
      r_idx    <= '0;
      r_acc    <= 1'b0;
    end else begin
      r_strobe <= w_play;
      if (!run) begin
        r_gate <= 1'b0;
        r_idx  <= '0;
        r_acc  <= 1'b0;
      end else if (w_play) begin
        r_idx  <= w_nidx;
        r_note <= w_rd[NOTE_W-1:0];
        r_gate <= |w_rd[NOTE_W-1:0];
        r_acc  <= w_rd[DW-1] & (DW > NOTE_W);
      end else if (w_fall && r_state != IDLE) begin
        r_gate <= 1'b0;
        r_acc  <= 1'b0;
      end
    end
  end

  assign note        = r_note;
  assign gate        = r_gate;
  assign step_strobe = r_strobe;
  assign step_idx    = r_idx;
  assign playing     = (r_state == PLAYING);
`ifdef SEQ_ACCENT_EN
  assign accent      = r_acc;
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: table of tempo periods
// plus hand sequences for stop/restart, full depth and async reset.
module tb_step_sequencer;

`ifdef SEQ_ACCENT_EN
  localparam int DW = 8;
`else
  localparam int DW = 7;
`endif

  logic          clk;
  logic          rst;
  logic          tick_in;
  logic          run;
  logic [3:0]    len_m1;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [6:0]    note;
  logic          gate;
  logic          step_strobe;
  logic [3:0]    step_idx;
  logic          playing;
`ifdef SEQ_ACCENT_EN
  logic          accent;
`endif

  step_sequencer #(.ADDR_W(4), .NOTE_W(7)) dut (
    .clk(clk),
    .rst(rst),
    .tick_in(tick_in),
    .run(run),
    .len_m1(len_m1),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .note(note),
    .gate(gate),
    .step_strobe(step_strobe),
    .step_idx(step_idx),
    .playing(playing)
`ifdef SEQ_ACCENT_EN
    ,
    .accent(accent)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] len;
    int         hi;
    int         wr_at;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] idx;
    logic [6:0] note;
    logic       gate;
    logic       acc;
  } row_t;

  int         ncmp;
  int         nbad;
  logic [7:0] mdl [16];
  row_t       tbl [11];

  function automatic row_t mk(input int len, input int wr_at,
                              input int wa, input int wd,
                              input int idx, input int nt,
                              input int g, input int a,
                              input int hi);
    row_t r;
    r.len   = 4'(len);
    r.hi    = hi;
    r.wr_at = wr_at;
    r.wa    = 4'(wa);
    r.wd    = 8'(wd);
    r.idx   = 4'(idx);
    r.note  = 7'(nt);
    r.gate  = 1'(g);
    r.acc   = 1'(a);
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = DW'(d);
    mdl[a]  = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One tempo period: tick high for hi clocks, low for hi clocks.
  task automatic play(input row_t r);
    int         lat;
    int         sc;
    int         gc;
    logic [3:0] ci;
    logic [6:0] cn;
    logic       cg;
`ifdef SEQ_ACCENT_EN
    logic       ca;
    ca = 1'b0;
`endif
    lat = 0;
    sc  = 0;
    gc  = 0;
    ci  = '0;
    cn  = '0;
    cg  = 1'b0;
    for (int i = 1; i <= 2 * r.hi; i++) begin
      @(negedge clk);
      tick_in = (i <= r.hi);
      len_m1  = r.len;
      wr_en   = (i == r.wr_at);
      wr_addr = r.wa;
      wr_data = DW'(r.wd);
      @(posedge clk);
      #1;
      if (step_strobe) begin
        sc++;
        if (sc == 1) begin
          lat = i;
          ci  = step_idx;
          cn  = note;
          cg  = gate;
`ifdef SEQ_ACCENT_EN
          ca  = accent;
`endif
        end
      end
      if (gate) gc++;
    end
    @(negedge clk);
    wr_en = 1'b0;
    if (r.wr_at != 0) mdl[r.wa] = r.wd;
    chk("strobe_count", sc, 1);
    chk("latency", lat, 3);
    chk("step_idx", int'(ci), int'(r.idx));
    chk("note", int'(cn), int'(r.note));
    chk("gate_at_step", int'(cg), int'(r.gate));
    chk("gate_len", gc, r.gate ? r.hi : 0);
`ifdef SEQ_ACCENT_EN
    chk("accent", int'(ca), int'(r.acc));
`endif
  endtask

  initial begin
    int bad;
    int k;
    ncmp    = 0;
    nbad    = 0;
    rst     = 1'b1;
    tick_in = 1'b0;
    run     = 1'b0;
    len_m1  = 4'd3;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'd0;

    tbl[0]  = mk(3, 0, 0, 0,    0, 60, 1, 1, 10);
    tbl[1]  = mk(3, 0, 0, 0,    1, 62, 1, 0, 10);
    tbl[2]  = mk(3, 0, 0, 0,    2, 0,  0, 0, 10);
    tbl[3]  = mk(3, 0, 0, 0,    3, 64, 1, 0, 10);
    tbl[4]  = mk(3, 0, 0, 0,    0, 60, 1, 1, 10);
    tbl[5]  = mk(7, 0, 0, 0,    1, 62, 1, 0, 10);
    tbl[6]  = mk(7, 0, 0, 0,    2, 0,  0, 0, 10);
    tbl[7]  = mk(7, 0, 0, 0,    3, 64, 1, 0, 10);
    tbl[8]  = mk(1, 3, 0, 72,   0, 60, 1, 1, 10);
    tbl[9]  = mk(1, 0, 0, 0,    1, 62, 1, 0, 10);
    tbl[10] = mk(1, 0, 0, 0,    0, 72, 1, 0, 10);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_note", int'(note), 0);
    chk("rst_gate", int'(gate), 0);
    chk("rst_strobe", int'(step_strobe), 0);
    chk("rst_idx", int'(step_idx), 0);
    chk("rst_playing", int'(playing), 0);
    @(negedge clk);
    rst = 1'b0;

    wr(0, 8'hBC);
    wr(1, 62);
    wr(2, 0);
    wr(3, 64);

    @(negedge clk);
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("armed_playing", int'(playing), 0);
    chk("armed_gate", int'(gate), 0);

    for (int i = 0; i < 11; i++) begin
      play(tbl[i]);
      chk("playing", int'(playing), 1);
    end

    // Stop mid-gate, then restart waits for a fresh tick rise.
    @(negedge clk);
    tick_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("a_strobe", int'(step_strobe), 1);
    chk("a_idx", int'(step_idx), 1);
    chk("a_gate", int'(gate), 1);
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    #1;
    chk("stop_playing", int'(playing), 0);
    chk("stop_gate", int'(gate), 0);
    chk("stop_idx", int'(step_idx), 0);
    chk("stop_note", int'(note), 62);
`ifdef SEQ_ACCENT_EN
    chk("stop_accent", int'(accent), 0);
`endif
    @(negedge clk);
    tick_in = 1'b0;
    repeat (8) @(negedge clk);
    run = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (step_strobe || gate || playing) bad++;
    end
    chk("rearm_quiet", bad, 0);
    play(mk(1, 0, 0, 0, 0, 72, 1, 0, 10));

    // Full depth at minimum tempo period: 15 wraps to 0.
    for (int i = 1; i <= 16; i++) begin
      k = i % 16;
      play(mk(15, 0, 0, 0, k, int'(mdl[k][6:0]),
              int'(mdl[k][6:0] != 7'd0), int'(mdl[k][7]), 4));
    end

    // Asynchronous reset while the gate is high.
    @(negedge clk);
    tick_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("c_gate", int'(gate), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_gate", int'(gate), 0);
    chk("async_note", int'(note), 0);
    chk("async_idx", int'(step_idx), 0);
    chk("async_playing", int'(playing), 0);
    @(negedge clk);
    tick_in = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'd0;
    repeat (2) @(negedge clk);
    play(mk(15, 0, 0, 0, 0, 0, 0, 0, 10));
    play(mk(15, 0, 0, 0, 1, 0, 0, 0, 10));
    play(mk(15, 0, 0, 0, 2, 0, 0, 0, 10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Tempo-driven note step sequencer. It consumes the slow square-wave tempo output of the clock divider and advances through a small writable pattern RAM, one step per tempo rising edge. It produces note/gate pairs for a downstream voice. It sits between the tempo clock divider and the voice/envelope stage.

Parameters:
ADDR_W, 4, step address width; pattern depth STEPS = 2**ADDR_W (default 16)
NOTE_W, 7, note value width; note value 0 means rest

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tick_in  in  1  tempo square wave from clock divider; treated as asynchronous
run  in  1  1 = sequencer running, 0 = stop
len_m1  in  ADDR_W  pattern length minus 1 (length = len_m1+1)
wr_en  in  1  pattern write strobe
wr_addr  in  ADDR_W  pattern write address
wr_data  in  NOTE_W (+1 with SEQ_ACCENT_EN)  pattern write data
note  out  NOTE_W  current step note
gate  out  1  note gate
step_strobe  out  1  one-clk pulse on each step advance
step_idx  out  ADDR_W  index of the step currently sounding
playing  out  1  high in PLAYING state

Behaviour:
- Reset (async, rst=1): state IDLE; note=0, gate=0, step_strobe=0, step_idx=0, playing=0; all pattern entries cleared to 0 (rest).
- tick_in passes through a 2-FF synchroniser plus one history FF (s1,s2,s3). rise = s2&~s3; fall = ~s2&s3.
- Latency: the clk edge that first samples tick_in=1 is E0. Outputs update on E2. Falling edges follow the same timing.
- State IDLE: gate=0, playing=0. If run=1, next state is ARMED.
- State ARMED: waits for rise. On rise, plays step 0 and moves to PLAYING.
  - This gives a deterministic start on a tempo boundary; no partial first step.
- State PLAYING: on rise, computes next = (step_idx >= len_m1) ? 0 : step_idx+1, then:
  - step_idx <= next; note <= pattern[next]
  - gate <= (pattern[next] != 0); step_strobe <= 1 for exactly one clk
- "Play step k" (in ARMED or PLAYING): step_idx=k, note=pattern[k], gate=(pattern[k]!=0), step_strobe pulses.
- On fall in ARMED or PLAYING: gate <= 0. note and step_idx are held, giving a 50% duty gate per step.
- Rest step (pattern value 0): note output updates to 0, gate stays 0, step_strobe still pulses.
- run=0 in any state: next edge goes to IDLE, gate <= 0, step_idx <= 0. note holds its last value.
- len_m1 changed while playing: takes effect at the next rise. If step_idx > new len_m1, that next rise wraps to 0.
- Pattern write: pattern[wr_addr] <= wr_data on clk edge when wr_en=1. Allowed in any state.
  - Write and step-read of the same address on the same edge: read-before-write, so the old value is played.
- Tempo period is at least 8 clk cycles. Faster tick_in is out of spec; no step may be skipped for legal tempos.
- Widths: step_idx arithmetic is modulo 2**ADDR_W. len_m1 = all ones uses the full depth.

Optional Feature:
SEQ_ACCENT_EN
- Defined:
  - wr_data is NOTE_W+1 bits; the MSB is the accent bit, stored per step.
  - Extra output accent (1 bit) is loaded with the accent bit whenever a step plays. It clears with gate on fall and on run=0.
  - Rest detection uses note bits only.
- Not defined: wr_data is NOTE_W bits; no accent storage or port.

Test Plan:
- Reset mid-play (rst pulsed while gate=1) -> gate=0, note=0, step_idx=0, playing=0 immediately (async); all entries read back as rest.
- Write pattern [60,62,0,64], len_m1=3, run=1, tick period 20 clk -> notes 60,62,0,64,60, step_idx 0,1,2,3,0; gate high 10 clk on non-rest steps, 0 on step 2.
- Latency check: tick_in rises just before edge E0 -> step_strobe, note and gate update on E2; step_strobe is high exactly 1 clk.
- Drop run to 0 at step 2 -> IDLE next edge, gate=0, step_idx=0. Re-raise run -> no output until next tick rise, then step 0 plays.
- While at step_idx=3, set len_m1 from 7 to 1 -> next rise plays step 0. Simultaneously write pattern[0]=72 on the rise-detect edge -> old value played; 72 is played next wrap.
- With SEQ_ACCENT_EN: step value {1,60} -> accent=1 with gate; value {0,62} -> accent=0.
